adder_tree_sequencer: RTL

//  Serial-to-parallel front end and sequencer for the 8-input Adder tree.

---
 rtl/adder_seq_pkg.sv | 14 +
 rtl/adder_tree_sequencer_adder.sv | 37 +++
 rtl/adder_tree_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/adder_seq_pkg.sv
// Shared constants and state encoding for the adder tree sequencer.
package adder_seq_pkg;

    localparam int LANES       = 8;
    localparam int CNT_W       = 3;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SUM     = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/adder_tree_sequencer_adder.sv
// Eight-input unsigned adder tree. Each level widens by one bit, so the
// final sum is DATAWIDTH+3 bits and can never overflow.
module adder_tree_sequencer_adder #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] in_0,
    input  logic [DATAWIDTH-1:0] in_1,
    input  logic [DATAWIDTH-1:0] in_2,
    input  logic [DATAWIDTH-1:0] in_3,
    input  logic [DATAWIDTH-1:0] in_4,
    input  logic [DATAWIDTH-1:0] in_5,
    input  logic [DATAWIDTH-1:0] in_6,
    input  logic [DATAWIDTH-1:0] in_7,
    output logic [DATAWIDTH+2:0] sum
);

    logic [DATAWIDTH:0]   pair_0;
    logic [DATAWIDTH:0]   pair_1;
    logic [DATAWIDTH:0]   pair_2;
    logic [DATAWIDTH:0]   pair_3;
    logic [DATAWIDTH+1:0] quad_0;
    logic [DATAWIDTH+1:0] quad_1;

    // First level: adjacent lane pairs.
    assign pair_0 = {1'b0, in_0} + {1'b0, in_1};
    assign pair_1 = {1'b0, in_2} + {1'b0, in_3};
    assign pair_2 = {1'b0, in_4} + {1'b0, in_5};
    assign pair_3 = {1'b0, in_6} + {1'b0, in_7};

    // Second level: pairs of pairs.
    assign quad_0 = {1'b0, pair_0} + {1'b0, pair_1};
    assign quad_1 = {1'b0, pair_2} + {1'b0, pair_3};

    // Root of the tree.
    assign sum = {1'b0, quad_0} + {1'b0, quad_1};

endmodule

// File: rtl/adder_tree_sequencer.sv
// Serial-to-parallel front end and sequencer for the 8-input adder tree.
// Collects up to eight samples (flush closes a partial frame), registers
// the tree sum and offers it on a valid/ready output stream.
// Optional macro ADDER_SEQ_MEAN_EN: output the truncated mean (sum / 8)
// instead of the full sum; ports and timing are unchanged.
module adder_tree_sequencer
    import adder_seq_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATAWIDTH-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [DATAWIDTH+2:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATAWIDTH-1:0]   lane_q [LANES];
    logic [DATAWIDTH+2:0]   out_data_q;
    logic                   out_valid_q;
    logic                   in_ready_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    logic                   accept;
    logic                   fill_last;
    logic                   close;
    logic [CNT_W:0]         zero_from;
    logic [DATAWIDTH+2:0]   tree_sum;
    logic [DATAWIDTH+2:0]   result;

    adder_tree_sequencer_adder #(
        .DATAWIDTH (DATAWIDTH)
    ) u_adder (
        .in_0 (lane_q[0]),
        .in_1 (lane_q[1]),
        .in_2 (lane_q[2]),
        .in_3 (lane_q[3]),
        .in_4 (lane_q[4]),
        .in_5 (lane_q[5]),
        .in_6 (lane_q[6]),
        .in_7 (lane_q[7]),
        .sum  (tree_sum)
    );

`ifdef ADDER_SEQ_MEAN_EN
    // Truncating divide by 8, applied to flushed frames as well.
    assign result = {3'b000, tree_sum[DATAWIDTH+2:3]};
`else
    assign result = tree_sum;
`endif

    // Frame-close decode: an accept takes priority over flush, and a flush
    // that coincides with the accept filling lane 7 is ignored.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        accept    = 1'b0;
        fill_last = 1'b0;
        close     = 1'b0;
        zero_from = {1'b0, cnt_q};
        if (state_q == COLLECT) begin
            accept    = in_valid && in_ready_q;
            fill_last = accept && (cnt_q == CNT_W'(LANES - 1));
            zero_from = {1'b0, cnt_q} + {{CNT_W{1'b0}}, accept};
            close     = flush && !fill_last && (zero_from != '0);
        end
    end

    // Sequencer FSM with lane buffer, output register and frame counter.
    // NOTE: the lane buffer is reset because reset must discard a partial frame and the tree reads unfilled lanes as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            frame_cnt_q <= '0;
            for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        lane_q[cnt_q] <= in_data;
                        if (fill_last) begin
                            state_q    <= SUM;
                            in_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    if (close) begin
                        for (int i = 0; i < LANES; i++) begin
                            if ((CNT_W+1)'(i) >= zero_from) lane_q[i] <= '0;
                        end
                        state_q    <= SUM;
                        in_ready_q <= 1'b0;
                    end
                end
                SUM: begin
                    out_data_q <= result;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b1;
                        state_q     <= COLLECT;
                        for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_cnt = frame_cnt_q;

endmodule
